// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
// Resolves load-use hazards, EX-stage redirects and multi-cycle data-memory
// accesses. Pipeline-register enables and flushes are combinational. A memory
// watchdog forces a release after MEM_TIMEOUT frozen wait cycles. Saturating
// counters record stall cycles and accepted redirects.
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic             i_ex_valid,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_mem_rden,
  input  logic             i_ex_redirect,
  input  logic             i_mem_req,
  input  logic             i_mem_ack,
  output logic             o_pc_en,
  output logic             o_if_id_en,
  output logic             o_id_ex_en,
  output logic             o_ex_mem_en,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic             o_mem_wb_bubble,
  output logic             o_mem_timeout,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  // The wait counter must be able to hold MEM_TIMEOUT itself.
  localparam int unsigned WaitW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);
  localparam logic [WaitW-1:0] WaitOne = WaitW'(1);
  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  typedef enum logic [0:0] {StRun, StMemWait} state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic mem_busy;
  logic rs1_hit;
  logic rs2_hit;
  logic freeze;
  logic redirect_take;

  // Hazard detection on the raw ID/EX/MEM stage information.
  always_comb begin
    rs1_hit  = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
    rs2_hit  = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
    load_use = i_ex_valid && i_ex_mem_rden && (i_ex_rd != 5'd0) && (rs1_hit || rs2_hit);
    mem_busy = i_mem_req && !i_mem_ack;
  end

  // Memory-wait sequencing: decides freeze vs. release and the watchdog.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    freeze    = 1'b0;
    unique case (state_q)
      StRun: begin
        if (mem_busy) begin
          freeze  = 1'b1;
          state_d = StMemWait;
          wait_d  = WaitOne;
        end
      end
      StMemWait: begin
        if (i_mem_ack) begin
          state_d = StRun;
          wait_d  = '0;
        end else if (wait_q < WaitMax) begin
          freeze = 1'b1;
          wait_d = wait_q + WaitOne;
        end else begin
          // Watchdog expiry: release exactly as on ack, but remember it.
          timeout_d = 1'b1;
          state_d   = StRun;
          wait_d    = '0;
        end
      end
    endcase
  end

  // Pipeline control outputs; freeze beats redirect beats load-use.
  always_comb begin
    o_pc_en         = 1'b1;
    o_if_id_en      = 1'b1;
    o_id_ex_en      = 1'b1;
    o_ex_mem_en     = 1'b1;
    o_if_id_flush   = 1'b0;
    o_id_ex_flush   = 1'b0;
    o_mem_wb_bubble = 1'b0;
    redirect_take   = 1'b0;
    if (i_reset) begin
      o_pc_en     = 1'b0;
      o_if_id_en  = 1'b0;
      o_id_ex_en  = 1'b0;
      o_ex_mem_en = 1'b0;
    end else if (freeze) begin
      o_pc_en         = 1'b0;
      o_if_id_en      = 1'b0;
      o_id_ex_en      = 1'b0;
      o_ex_mem_en     = 1'b0;
      o_mem_wb_bubble = 1'b1;
    end else if (i_ex_redirect) begin
      // Younger instructions are discarded, so a load-use hazard is moot.
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
      redirect_take = 1'b1;
    end else if (load_use) begin
      // Hold IF/ID for one cycle and insert a bubble behind the load.
      o_pc_en       = 1'b0;
      o_if_id_en    = 1'b0;
      o_id_ex_flush = 1'b1;
    end
  end

  // Saturating performance counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!i_reset && !o_pc_en && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + CntOne;
    end
    if (redirect_take && (flush_cnt_q != CntMax)) begin
      flush_cnt_d = flush_cnt_q + CntOne;
    end
  end

  // State, wait counter, watchdog flag and counters.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= StRun;
      wait_q      <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_mem_timeout = timeout_q;
  assign o_stall_cnt   = stall_cnt_q;
  assign o_flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a rule-level model checked every cycle on the
// falling edge, plus directed scenarios with hand-computed literal expectations.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CW  = 4;
  localparam int unsigned TO  = 4;
  localparam int          MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    rs1, rs2, ex_rd;
  logic          use1, use2, ex_valid, ex_rden, redirect, req, ack;
  logic          pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic          if_id_flush, id_ex_flush, bubble, timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  // Model state: waiting flag, frozen cycles in the current access, sticky flag, counts.
  bit m_wait;
  int m_waited;
  bit m_to;
  int m_stall;
  int m_flush;

  pipe_hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_id_rs1       (rs1),
    .i_id_rs2       (rs2),
    .i_id_use_rs1   (use1),
    .i_id_use_rs2   (use2),
    .i_ex_valid     (ex_valid),
    .i_ex_rd        (ex_rd),
    .i_ex_mem_rden  (ex_rden),
    .i_ex_redirect  (redirect),
    .i_mem_req      (req),
    .i_mem_ack      (ack),
    .o_pc_en        (pc_en),
    .o_if_id_en     (if_id_en),
    .o_id_ex_en     (id_ex_en),
    .o_ex_mem_en    (ex_mem_en),
    .o_if_id_flush  (if_id_flush),
    .o_id_ex_flush  (id_ex_flush),
    .o_mem_wb_bubble(bubble),
    .o_mem_timeout  (timeout),
    .o_stall_cnt    (stall_cnt),
    .o_flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {pc, if_id, id_ex, ex_mem, if_id_flush, id_ex_flush, bubble, timeout}.
  function automatic logic [7:0] exp_ctrl();
    bit lu, busy;
    lu = ex_valid && ex_rden && (ex_rd != 0) &&
         ((use1 && rs1 == ex_rd) || (use2 && rs2 == ex_rd));
    if (m_wait) busy = !ack && (m_waited < TO);
    else        busy = req && !ack;
    if (rst)      return 8'b0000_0000;
    if (busy)     return {7'b0000_001, m_to};
    if (redirect) return {7'b1111_110, m_to};
    if (lu)       return {7'b0011_010, m_to};
    return {7'b1111_000, m_to};
  endfunction

  // Model update; stimulus changes 1 time unit after the edge so inputs are stable here.
  always @(posedge clk or posedge rst) begin
    logic [7:0] e;
    if (rst) begin
      m_wait = 0; m_waited = 0; m_to = 0; m_stall = 0; m_flush = 0;
    end else begin
      e = exp_ctrl();
      if (!e[7] && m_stall < MAX) m_stall++;
      if (redirect && !e[1] && m_flush < MAX) m_flush++;
      if (m_wait) begin
        if (e[1]) m_waited++;
        else begin
          if (!ack) m_to = 1;
          m_wait = 0; m_waited = 0;
        end
      end else if (e[1]) begin
        m_wait = 1; m_waited = 1;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("ctrl", {24'd0, pc_en, if_id_en, id_ex_en, ex_mem_en,
                   if_id_flush, id_ex_flush, bubble, timeout}, {24'd0, exp_ctrl()});
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1 = 0; rs2 = 0; ex_rd = 0; use1 = 0; use2 = 0; ex_valid = 0;
    ex_rden = 0; redirect = 0; req = 0; ack = 0;
  endtask

  task automatic set_load_use();
    ex_valid = 1; ex_rden = 1; ex_rd = 5; rs1 = 3; use1 = 1; rs2 = 5; use2 = 1;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    #1;
    check("reset_pc_en", 32'(pc_en), 0);
    check("reset_flush", 32'(if_id_flush), 0);
    tick(); tick();
    rst = 0;
    check("reset_stall_cnt", 32'(stall_cnt), 0);

    // Load-use: one-cycle stall.
    set_load_use(); #1;
    check("lu_pc_en", 32'(pc_en), 0);
    check("lu_id_ex_flush", 32'(id_ex_flush), 1);
    tick(); idle(); #1;
    check("lu_after_pc_en", 32'(pc_en), 1);
    tick();
    check("lu_stall_cnt", 32'(stall_cnt), 1);
    // rd = x0 never hazards.
    ex_valid = 1; ex_rden = 1; ex_rd = 0; rs2 = 0; use2 = 1; #1;
    check("lu_x0_pc_en", 32'(pc_en), 1);
    tick(); idle();
    check("lu_x0_stall_cnt", 32'(stall_cnt), 1);

    // Redirect beats a simultaneous load-use.
    set_load_use(); redirect = 1; #1;
    check("redir_pc_en", 32'(pc_en), 1);
    check("redir_if_id_flush", 32'(if_id_flush), 1);
    check("redir_id_ex_flush", 32'(id_ex_flush), 1);
    tick(); idle();
    check("redir_flush_cnt", 32'(flush_cnt), 1);
    check("redir_stall_cnt", 32'(stall_cnt), 1);

    // Three-cycle memory wait, then a zero-wait access.
    do_reset();
    req = 1; #1;
    check("mw_bubble", 32'(bubble), 1);
    tick(); tick(); tick();
    ack = 1; #1;
    check("mw_release_pc_en", 32'(pc_en), 1);
    check("mw_release_bubble", 32'(bubble), 0);
    tick(); idle();
    check("mw_stall_cnt", 32'(stall_cnt), 3);
    req = 1; ack = 1; #1;
    check("mw_zero_pc_en", 32'(pc_en), 1);
    tick(); idle();
    check("mw_zero_stall_cnt", 32'(stall_cnt), 3);

    // Redirect during MEM_WAIT is deferred to the ack cycle.
    req = 1; redirect = 1; #1;
    check("mwr_flush0", 32'(if_id_flush), 0);
    tick(); #1;
    check("mwr_flush1", 32'(if_id_flush), 0);
    tick();
    ack = 1; #1;
    check("mwr_ack_flush", 32'(if_id_flush), 1);
    check("mwr_ack_pc_en", 32'(pc_en), 1);
    tick(); idle();
    check("mwr_flush_cnt", 32'(flush_cnt), 1);
    check("mwr_stall_cnt", 32'(stall_cnt), 5);

    // Watchdog: no ack ever.
    do_reset();
    req = 1;
    tick(); tick(); tick(); tick();
    #1;
    check("wd_release_pc_en", 32'(pc_en), 1);
    check("wd_flag_before", 32'(timeout), 0);
    tick();
    check("wd_flag_set", 32'(timeout), 1);
    tick();
    req = 0; ack = 1;
    tick(); idle();
    check("wd_stall_cnt", 32'(stall_cnt), 5);
    check("wd_flag_sticky", 32'(timeout), 1);
    check("wd_idle_pc_en", 32'(pc_en), 1);

    // Reset in the middle of a wait.
    req = 1;
    tick(); tick();
    rst = 1; #1;
    check("rmw_flag", 32'(timeout), 0);
    check("rmw_stall_cnt", 32'(stall_cnt), 0);
    check("rmw_pc_en", 32'(pc_en), 0);
    tick();
    rst = 0; idle(); #1;
    check("rmw_run_pc_en", 32'(pc_en), 1);
    tick();

    // Saturation at 2^CW-1.
    redirect = 1;
    repeat (20) tick();
    check("sat_flush_cnt", 32'(flush_cnt), 15);
    idle(); set_load_use();
    repeat (20) tick();
    check("sat_stall_cnt", 32'(stall_cnt), 15);
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Stall and flush sequencer for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
- Detects load-use hazards and EX-stage redirects (taken branch, jal/jalr).
- Freezes the pipeline while a multi-cycle data-memory access is outstanding.
- Drives every pipeline-register enable and flush, plus stall/flush performance counters and a memory watchdog flag.

Parameters:
- CNT_W, 32, width of the saturating performance counters.
- MEM_TIMEOUT, 16, maximum MEM_WAIT cycles before the watchdog forces release (must be >= 1).

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_id_rs1  in  5  rs1 index of the instruction in ID.
- i_id_rs2  in  5  rs2 index of the instruction in ID.
- i_id_use_rs1  in  1  ID instruction reads rs1.
- i_id_use_rs2  in  1  ID instruction reads rs2.
- i_ex_valid  in  1  EX holds a real (non-bubble) instruction.
- i_ex_rd  in  5  destination register of the EX instruction.
- i_ex_mem_rden  in  1  EX instruction is a load.
- i_ex_redirect  in  1  EX resolved a taken branch or a jump.
- i_mem_req  in  1  MEM stage is issuing a load or store.
- i_mem_ack  in  1  data memory completes the access this cycle.
- o_pc_en  out  1  PC update enable.
- o_if_id_en  out  1  IF/ID register enable.
- o_id_ex_en  out  1  ID/EX register enable.
- o_ex_mem_en  out  1  EX/MEM register enable.
- o_if_id_flush  out  1  IF/ID loads a NOP.
- o_id_ex_flush  out  1  ID/EX loads a bubble.
- o_mem_wb_bubble  out  1  MEM/WB captures a bubble (rd_wren=0).
- o_mem_timeout  out  1  sticky watchdog-expiry flag.
- o_stall_cnt  out  CNT_W  number of cycles with o_pc_en=0.
- o_flush_cnt  out  CNT_W  number of accepted redirects.

Behaviour:
- Control outputs are combinational from current state and inputs (zero latency). State, counters and o_mem_timeout are registered.
- While i_reset=1:
  - all enables=0 and all flush/bubble outputs=0;
  - state=RUN, wait counter=0, o_mem_timeout=0, both performance counters=0.
- Hazard definitions:
  - load_use = i_ex_valid & i_ex_mem_rden & (i_ex_rd != 0) & ((i_id_use_rs1 & i_id_rs1 == i_ex_rd) | (i_id_use_rs2 & i_id_rs2 == i_ex_rd)).
  - mem_busy = i_mem_req & ~i_mem_ack.
- Default (no event): all enables=1, all flushes/bubble=0.
- State RUN, evaluated in priority order:
  1. mem_busy:
     - o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en = 0; o_mem_wb_bubble=1.
     - redirect and load_use are ignored this cycle.
     - next state=MEM_WAIT, wait counter=1.
  2. i_ex_redirect:
     - o_if_id_flush=1, o_id_ex_flush=1, o_pc_en=1 (PC takes the target), other enables=1.
     - load_use is ignored, because the younger instruction is discarded.
     - o_flush_cnt increments.
  3. load_use:
     - o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1, o_ex_mem_en=1.
     - Lasts exactly one cycle, because the load advances to MEM.
- State MEM_WAIT:
  - While ~i_mem_ack and wait counter < MEM_TIMEOUT: full freeze as in RUN case 1; wait counter increments.
  - On i_mem_ack:
    - outputs are those of RUN with mem_busy forced 0 (redirect/load_use evaluated normally), so the pipeline advances this cycle;
    - next state=RUN, wait counter=0.
  - If wait counter == MEM_TIMEOUT and no ack:
    - o_mem_timeout is set (it stays 1 until reset);
    - behave exactly as on ack, i.e. release to RUN.
- A new i_mem_req in the cycle after release is a new access and re-enters MEM_WAIT if not acked.
- Single-cycle access (i_mem_req & i_mem_ack in the same cycle) causes no stall.
- o_stall_cnt increments on every cycle with o_pc_en=0 (excluding reset).
- Both performance counters saturate at 2^CNT_W-1 and never wrap.
- Reset asserted mid-MEM_WAIT:
  - immediate return to RUN and counters cleared;
  - o_mem_timeout cleared.

Test Plan:
- Load-use: lw x5 in EX (i_ex_rd=5, i_ex_mem_rden=1), ID add using rs2=5 -> exactly 1 cycle with o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1; o_stall_cnt=1. Repeat with i_ex_rd=0 -> no stall.
- Redirect with a simultaneous load_use -> o_if_id_flush=o_id_ex_flush=1, o_pc_en=1, no stall; o_flush_cnt 0->1.
- Memory wait: i_mem_req held and i_mem_ack after 3 cycles -> 3 cycles of freeze with o_mem_wb_bubble=1, release on the ack cycle, o_stall_cnt=3; zero-wait access -> no stall.
- Redirect asserted during MEM_WAIT -> ignored until the ack cycle, then flushes taken that cycle.
- Watchdog: MEM_TIMEOUT=4, ack never arrives -> freeze for 4 cycles, then release, o_mem_timeout=1 sticky; assert i_reset mid-wait in a second run -> RUN, flag and counters 0.
- Saturation: CNT_W=4, 20 redirects -> o_flush_cnt holds 15.
